// File: rtl/seg7_scan_decoder_pkg.sv
// seg7_scan_decoder_pkg
// Constants shared between the seven-segment scan decoder and the encoder
// side: canonical glyphs, alternate glyphs, and digit-select indices.
// Segment bit 0 is segment a, bit 6 is segment g.

package seg7_scan_decoder_pkg;

    // Canonical glyphs for digits 0..9
    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7C;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h67;

    // Alternate renderings some drivers use (tailed 6/9, hooked 7)
    localparam logic [6:0] GLYPH_ALT_6 = 7'h7D;
    localparam logic [6:0] GLYPH_ALT_7 = 7'h27;
    localparam logic [6:0] GLYPH_ALT_9 = 7'h6F;

    // Value reported for anything that is not a legal digit
    localparam logic [3:0] DIGIT_BAD = 4'hF;

    // Digit positions; also the bit position in the select bus
    localparam logic [1:0] MIN_U = 2'd0;
    localparam logic [1:0] MIN_D = 2'd1;
    localparam logic [1:0] HRS_U = 2'd2;
    localparam logic [1:0] HRS_D = 2'd3;

    localparam int unsigned NUM_DIGITS = 4;

    // True when exactly one select line is active
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Position of the active line of a one-hot select (MIN_U if not one-hot)
    function automatic logic [1:0] onehot4_to_idx(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0010: idx = MIN_D;
            4'b0100: idx = HRS_U;
            4'b1000: idx = HRS_D;
            default: idx = MIN_U;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg7_scan_decoder_glyph.sv
// seg7_glyph_decode
// Combinational seven-segment glyph to BCD decoder.
// Optional feature macro: SEG7_DEC_ALT_GLYPH_EN -- when defined, the
// alternate glyphs for 6, 7 and 9 are accepted as legal digits; otherwise
// they are reported as illegal like any other unknown pattern.

module seg7_glyph_decode
    import seg7_scan_decoder_pkg::*;
(
    input  logic [6:0] glyph_i,
    output logic [3:0] value_o,
    output logic       err_o
);

    // Table lookup; anything unlisted (including blank) is an error
    always_comb begin
        value_o = DIGIT_BAD;
        err_o   = 1'b1;
        case (glyph_i)
            GLYPH_0: begin value_o = 4'd0; err_o = 1'b0; end
            GLYPH_1: begin value_o = 4'd1; err_o = 1'b0; end
            GLYPH_2: begin value_o = 4'd2; err_o = 1'b0; end
            GLYPH_3: begin value_o = 4'd3; err_o = 1'b0; end
            GLYPH_4: begin value_o = 4'd4; err_o = 1'b0; end
            GLYPH_5: begin value_o = 4'd5; err_o = 1'b0; end
            GLYPH_6: begin value_o = 4'd6; err_o = 1'b0; end
            GLYPH_7: begin value_o = 4'd7; err_o = 1'b0; end
            GLYPH_8: begin value_o = 4'd8; err_o = 1'b0; end
            GLYPH_9: begin value_o = 4'd9; err_o = 1'b0; end
`ifdef SEG7_DEC_ALT_GLYPH_EN
            GLYPH_ALT_6: begin value_o = 4'd6; err_o = 1'b0; end
            GLYPH_ALT_7: begin value_o = 4'd7; err_o = 1'b0; end
            GLYPH_ALT_9: begin value_o = 4'd9; err_o = 1'b0; end
`else
            GLYPH_ALT_6, GLYPH_ALT_7, GLYPH_ALT_9: begin
                value_o = DIGIT_BAD;
                err_o   = 1'b1;
            end
`endif
            default: begin
                value_o = DIGIT_BAD;
                err_o   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Receive side of a multiplexed 4-digit seven-segment display. Samples the
// segment/point/select lines, waits for each digit's drive to settle,
// decodes it into a shadow slot, and commits all four slots as one frame
// once every digit has been seen. Flags the display as stale when no digit
// has been captured for TIMEOUT_CYCLES.
// Optional feature macro: SEG7_DEC_ALT_GLYPH_EN (see seg7_glyph_decode).

module seg7_scan_decoder
    import seg7_scan_decoder_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,      // 1..255
    parameter int unsigned TIMEOUT_CYCLES = 65536   // 2..2^24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg_in,
    input  logic        dp_in,
    input  logic [3:0]  sel_in,
    input  logic        seg_active_low,
    input  logic        sel_active_low,
    output logic [15:0] digits_out,
    output logic [3:0]  dp_out,
    output logic [3:0]  digit_err,
    output logic        frame_valid,
    output logic        stale
);

    localparam logic [7:0]  SETTLE_MAX = 8'(SETTLE_CYCLES);
    localparam logic [7:0]  SETTLE_M1  = 8'(SETTLE_CYCLES - 1);
    localparam logic [24:0] TMO_MAX    = 25'(TIMEOUT_CYCLES);
    localparam logic [24:0] TMO_M1     = 25'(TIMEOUT_CYCLES - 1);

    // Synchronizer stages
    logic [6:0] seg_s1_q, seg_s2_q;
    logic       dp_s1_q, dp_s2_q;
    logic [3:0] sel_s1_q, sel_s2_q;

    // Normalized (active-high) sampled word
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  sel_n;
    logic [11:0] word_n;

    // Stability tracking
    logic [11:0] prev_q, prev_d;
    logic [7:0]  stab_q, stab_d;
    logic        word_same;
    logic        cap;
    logic [1:0]  cap_idx;

    // Decoded glyph
    logic [3:0] dec_value;
    logic       dec_err;

    // Shadow frame
    logic [3:0][3:0] shadow_val_q;
    logic [3:0]      shadow_dp_q;
    logic [3:0]      shadow_err_q;
    logic [3:0]      captured_q, captured_d;
    logic            commit;

    // Idle / stale tracking
    logic [24:0] idle_q, idle_d;
    logic        timeout_evt;
    logic        stale_q, stale_d;

    // Output registers
    logic [3:0][3:0] digits_q, digits_d;
    logic [3:0]      dp_q, dp_d;
    logic [3:0]      err_q, err_d;
    logic            fv_q, fv_d;

    // Two-flop synchronizer on every display line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_s1_q <= 7'd0;
            seg_s2_q <= 7'd0;
            dp_s1_q  <= 1'b0;
            dp_s2_q  <= 1'b0;
            sel_s1_q <= 4'd0;
            sel_s2_q <= 4'd0;
        end else begin
            seg_s1_q <= seg_in;
            seg_s2_q <= seg_s1_q;
            dp_s1_q  <= dp_in;
            dp_s2_q  <= dp_s1_q;
            sel_s1_q <= sel_in;
            sel_s2_q <= sel_s1_q;
        end
    end

    // Polarity controls are static straps, so they are applied unsynchronized
    always_comb begin
        seg_n  = seg_s2_q ^ {7{seg_active_low}};
        dp_n   = dp_s2_q ^ seg_active_low;
        sel_n  = sel_s2_q ^ {4{sel_active_low}};
        word_n = {sel_n, dp_n, seg_n};
    end

    // Settle counter: restarts on any change, saturates so capture fires
    // exactly once per dwell
    always_comb begin
        word_same = (word_n == prev_q);
        prev_d    = word_n;
        if (!word_same) begin
            stab_d = 8'd0;
        end else if (stab_q != SETTLE_MAX) begin
            stab_d = stab_q + 8'd1;
        end else begin
            stab_d = stab_q;
        end
        cap     = word_same && (stab_q == SETTLE_M1) && is_onehot4(sel_n);
        cap_idx = onehot4_to_idx(sel_n);
    end

    // Stability state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 12'd0;
            stab_q <= 8'd0;
        end else begin
            prev_q <= prev_d;
            stab_q <= stab_d;
        end
    end

    seg7_glyph_decode u_glyph_decode (
        .glyph_i (seg_n),
        .value_o (dec_value),
        .err_o   (dec_err)
    );

    // Shadow slots: a recapture before commit simply overwrites the slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_val_q <= '0;
            shadow_dp_q  <= 4'd0;
            shadow_err_q <= 4'd0;
        end else if (cap) begin
            shadow_val_q[cap_idx] <= dec_value;
            shadow_dp_q[cap_idx]  <= dp_n;
            shadow_err_q[cap_idx] <= dec_err;
        end
    end

    // Commit uses the captured set as it stood before this cycle; a capture
    // landing on the same edge survives the clear and starts the next frame.
    // A capture also beats a timeout on the same edge.
    always_comb begin
        commit      = (captured_q == 4'hF);
        timeout_evt = !cap && (idle_q == TMO_M1);

        captured_d = captured_q;
        if (commit || timeout_evt) begin
            captured_d = 4'd0;
        end
        if (cap) begin
            captured_d = captured_d | sel_n;
        end

        if (cap) begin
            idle_d = 25'd0;
        end else if (idle_q != TMO_MAX) begin
            idle_d = idle_q + 25'd1;
        end else begin
            idle_d = idle_q;
        end

        stale_d = stale_q;
        if (commit) begin
            stale_d = 1'b0;
        end else if (timeout_evt) begin
            stale_d = 1'b1;
        end
    end

    // Frame assembly and idle tracking registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            captured_q <= 4'd0;
            idle_q     <= 25'd0;
            stale_q    <= 1'b1;
        end else begin
            captured_q <= captured_d;
            idle_q     <= idle_d;
            stale_q    <= stale_d;
        end
    end

    // Published frame holds until the next commit
    always_comb begin
        fv_d     = commit;
        digits_d = digits_q;
        dp_d     = dp_q;
        err_d    = err_q;
        if (commit) begin
            digits_d = shadow_val_q;
            dp_d     = shadow_dp_q;
            err_d    = shadow_err_q;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits_q <= '0;
            dp_q     <= 4'd0;
            err_q    <= 4'd0;
            fv_q     <= 1'b0;
        end else begin
            digits_q <= digits_d;
            dp_q     <= dp_d;
            err_q    <= err_d;
            fv_q     <= fv_d;
        end
    end

    assign digits_out  = digits_q;
    assign dp_out      = dp_q;
    assign digit_err   = err_q;
    assign frame_valid = fv_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Testbench for seg7_scan_decoder (SETTLE_CYCLES=4, TIMEOUT_CYCLES=100).

module tb_seg7_scan_decoder;

    localparam int SETTLE = 4;
    localparam int TMO    = 100;
    localparam int DWELL  = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  seg_in = 7'd0;
    logic        dp_in = 1'b0;
    logic [3:0]  sel_in = 4'd0;
    logic        seg_active_low = 1'b0;
    logic        sel_active_low = 1'b0;
    logic [15:0] digits_out;
    logic [3:0]  dp_out;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        stale;

    int n_checks = 0;
    int n_fail   = 0;

    int          cyc = 0;
    int          fv_count = 0;
    int          fv_cyc = 0;
    logic [15:0] fv_digits = '0;
    logic [3:0]  fv_dp = '0;
    logic [3:0]  fv_err = '0;
    logic        fv_stale = 1'b0;
    int          hd_start_cyc = 0;

    seg7_scan_decoder #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .seg_in         (seg_in),
        .dp_in          (dp_in),
        .sel_in         (sel_in),
        .seg_active_low (seg_active_low),
        .sel_active_low (sel_active_low),
        .digits_out     (digits_out),
        .dp_out         (dp_out),
        .digit_err      (digit_err),
        .frame_valid    (frame_valid),
        .stale          (stale)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            fv_count  = fv_count + 1;
            fv_cyc    = cyc;
            fv_digits = digits_out;
            fv_dp     = dp_out;
            fv_err    = digit_err;
            fv_stale  = stale;
        end
    end

    function automatic logic [6:0] glyph(input int d);
        logic [6:0] g;
        case (d)
            0: g = 7'h3F;  1: g = 7'h06;  2: g = 7'h5B;  3: g = 7'h4F;
            4: g = 7'h66;  5: g = 7'h6D;  6: g = 7'h7C;  7: g = 7'h07;
            8: g = 7'h7F;  9: g = 7'h67;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    // Put one digit on the wires (as the driver would) for n cycles
    task automatic drive(input logic [3:0] sel, input logic [6:0] g, input logic dp, input int n);
        seg_in = seg_active_low ? ~g : g;
        dp_in  = seg_active_low ? ~dp : dp;
        sel_in = sel_active_low ? ~sel : sel;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_idle(input int n);
        drive(4'b0000, 7'h00, 1'b0, n);
    endtask

    // Scan order min_u, min_d, hrs_u, hrs_d; dps is {hrs_d,hrs_u,min_d,min_u}
    task automatic scan(input logic [6:0] g_hd, input logic [6:0] g_hu,
                        input logic [6:0] g_md, input logic [6:0] g_mu,
                        input logic [3:0] dps);
        drive(4'b0001, g_mu, dps[0], DWELL);
        drive(4'b0010, g_md, dps[1], DWELL);
        drive(4'b0100, g_hu, dps[2], DWELL);
        hd_start_cyc = cyc;
        drive(4'b1000, g_hd, dps[3], DWELL);
        drive_idle(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (digits_out !== 16'h0000) begin n_fail++; $display("FAIL reset_digits: got %h want %h", digits_out, 16'h0000); end
        n_checks++; if (dp_out !== 4'h0) begin n_fail++; $display("FAIL reset_dp: got %h want %h", dp_out, 4'h0); end
        n_checks++; if (digit_err !== 4'h0) begin n_fail++; $display("FAIL reset_err: got %h want %h", digit_err, 4'h0); end
        n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
        n_checks++; if (stale !== 1'b1) begin n_fail++; $display("FAIL reset_stale: got %b want 1", stale); end
        reset = 1'b0;
        drive_idle(3);
    endtask

    task automatic test_scan_basic();
        int c0;
        c0 = fv_count;
        scan(glyph(1), glyph(2), glyph(3), glyph(4), 4'b0000);
        n_checks++; if (fv_count !== c0 + 1) begin n_fail++; $display("FAIL basic_fv_count: got %0d want %0d", fv_count - c0, 1); end
        n_checks++; if (digits_out !== 16'h1234) begin n_fail++; $display("FAIL basic_digits: got %h want %h", digits_out, 16'h1234); end
        n_checks++; if (fv_digits !== 16'h1234) begin n_fail++; $display("FAIL basic_fv_digits: got %h want %h", fv_digits, 16'h1234); end
        n_checks++; if (digit_err !== 4'h0) begin n_fail++; $display("FAIL basic_err: got %h want %h", digit_err, 4'h0); end
        n_checks++; if (dp_out !== 4'h0) begin n_fail++; $display("FAIL basic_dp: got %h want %h", dp_out, 4'h0); end
        // wire change -> 2 sync + 1 change + SETTLE to capture -> +1 commit
        n_checks++; if (fv_cyc !== hd_start_cyc + SETTLE + 4) begin n_fail++; $display("FAIL basic_fv_latency: got %0d want %0d", fv_cyc - hd_start_cyc, SETTLE + 4); end
        n_checks++; if (fv_stale !== 1'b0 || stale !== 1'b0) begin n_fail++; $display("FAIL basic_stale_clear: got %b/%b want 0/0", fv_stale, stale); end
    endtask

    task automatic test_polarity();
        int c0;
        c0 = fv_count;
        seg_active_low = 1'b1;
        sel_active_low = 1'b1;
        drive_idle(4);
        scan(glyph(1), glyph(2), glyph(3), glyph(4), 4'b0100);
        n_checks++; if (fv_count !== c0 + 1) begin n_fail++; $display("FAIL pol_fv_count: got %0d want %0d", fv_count - c0, 1); end
        n_checks++; if (digits_out !== 16'h1234) begin n_fail++; $display("FAIL pol_digits: got %h want %h", digits_out, 16'h1234); end
        n_checks++; if (dp_out !== 4'b0100) begin n_fail++; $display("FAIL pol_dp: got %b want %b", dp_out, 4'b0100); end
        n_checks++; if (digit_err !== 4'h0) begin n_fail++; $display("FAIL pol_err: got %h want %h", digit_err, 4'h0); end
        seg_active_low = 1'b0;
        sel_active_low = 1'b0;
        drive_idle(4);
    endtask

    task automatic test_glitch();
        int c0;
        c0 = fv_count;
        drive(4'b0011, glyph(9), 1'b0, 2);
        drive(4'b0001, glyph(9), 1'b0, 3);
        drive(4'b0010, glyph(5), 1'b0, DWELL);
        drive(4'b0100, glyph(0), 1'b0, DWELL);
        drive(4'b1000, glyph(2), 1'b0, DWELL);
        drive_idle(2);
        n_checks++; if (fv_count !== c0) begin n_fail++; $display("FAIL glitch_no_frame: got %0d frames want 0", fv_count - c0); end
        n_checks++; if (digits_out !== 16'h1234) begin n_fail++; $display("FAIL glitch_hold: got %h want %h", digits_out, 16'h1234); end
        drive(4'b0001, glyph(7), 1'b0, DWELL);
        drive_idle(2);
        n_checks++; if (fv_count !== c0 + 1) begin n_fail++; $display("FAIL glitch_then_frame: got %0d want %0d", fv_count - c0, 1); end
        n_checks++; if (digits_out !== 16'h2057) begin n_fail++; $display("FAIL glitch_digits: got %h want %h", digits_out, 16'h2057); end
    endtask

    task automatic test_alt_glyph();
        logic [15:0] exp_d;
        logic [3:0]  exp_e;
`ifdef SEG7_DEC_ALT_GLYPH_EN
        exp_d = 16'h08F6;
        exp_e = 4'b0010;
`else
        exp_d = 16'h08FF;
        exp_e = 4'b0011;
`endif
        scan(glyph(0), glyph(8), 7'h00, 7'h7D, 4'b0000);
        n_checks++; if (digits_out !== exp_d) begin n_fail++; $display("FAIL alt_digits: got %h want %h", digits_out, exp_d); end
        n_checks++; if (digit_err !== exp_e) begin n_fail++; $display("FAIL alt_err: got %b want %b", digit_err, exp_e); end
    endtask

    task automatic test_stale();
        int guard;
        int c0;
        guard = 0;
        while (cyc < fv_cyc + TMO - 2 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        n_checks++; if (guard >= 1000) begin n_fail++; $display("FAIL stale_wait: timed out after %0d cycles", guard); end
        n_checks++; if (stale !== 1'b0) begin n_fail++; $display("FAIL stale_early: got %b want 0 at %0d cycles", stale, cyc - fv_cyc); end
        @(negedge clk);
        n_checks++; if (stale !== 1'b1) begin n_fail++; $display("FAIL stale_assert: got %b want 1 at %0d cycles", stale, cyc - fv_cyc); end
        n_checks++; if (digits_out !== fv_digits) begin n_fail++; $display("FAIL stale_hold: got %h want %h", digits_out, fv_digits); end
        c0 = fv_count;
        scan(glyph(0), glyph(9), glyph(3), glyph(8), 4'b0000);
        n_checks++; if (fv_count !== c0 + 1) begin n_fail++; $display("FAIL stale_rescan_fv: got %0d want %0d", fv_count - c0, 1); end
        n_checks++; if (fv_stale !== 1'b0) begin n_fail++; $display("FAIL stale_clear_with_fv: got %b want 0", fv_stale); end
        n_checks++; if (digits_out !== 16'h0938) begin n_fail++; $display("FAIL stale_rescan_digits: got %h want %h", digits_out, 16'h0938); end
    endtask

    task automatic test_reset_midframe();
        int c0;
        drive(4'b0001, glyph(6), 1'b1, DWELL);
        drive(4'b0010, glyph(6), 1'b1, DWELL);
        reset = 1'b1;
        drive_idle(3);
        n_checks++; if (digits_out !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_digits: got %h want %h", digits_out, 16'h0000); end
        n_checks++; if (stale !== 1'b1) begin n_fail++; $display("FAIL rst_mid_stale: got %b want 1", stale); end
        reset = 1'b0;
        drive_idle(3);
        c0 = fv_count;
        drive(4'b0100, glyph(4), 1'b0, DWELL);
        drive(4'b1000, glyph(5), 1'b0, DWELL);
        drive_idle(2);
        n_checks++; if (fv_count !== c0) begin n_fail++; $display("FAIL rst_mid_partial_discard: got %0d frames want 0", fv_count - c0); end
        drive(4'b0001, glyph(1), 1'b0, DWELL);
        drive(4'b0010, glyph(2), 1'b0, DWELL);
        drive_idle(2);
        n_checks++; if (fv_count !== c0 + 1) begin n_fail++; $display("FAIL rst_mid_one_frame: got %0d want %0d", fv_count - c0, 1); end
        n_checks++; if (digits_out !== 16'h5421) begin n_fail++; $display("FAIL rst_mid_digits_new: got %h want %h", digits_out, 16'h5421); end
        n_checks++; if (dp_out !== 4'h0) begin n_fail++; $display("FAIL rst_mid_dp_new: got %h want %h", dp_out, 4'h0); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_scan_basic();
        test_polarity();
        test_glitch();
        test_alt_glyph();
        test_stale();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side companion of the multiplexed 4-digit seven-segment clock driver. Samples the time-multiplexed segment, decimal-point and digit-select lines that the clock drives, reconstructs the four BCD digits (HH:MM) and the four point LEDs, and presents them as a coherent frame. Used as a bench monitor and as the input stage of a board that mirrors or logs the displayed time.

## Interface
- `SETTLE_CYCLES`, default 4: consecutive identical synchronized samples required before a digit is captured; range 1–255.
- `TIMEOUT_CYCLES`, default 65536: cycles without any capture before `stale` asserts; range 2–2^24.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `seg_in` in 7: segments a–g, bit 0 = a.
- `dp_in` in 1: point LED line.
- `sel_in` in 4: digit select; bit0 = min_u, bit1 = min_d, bit2 = hrs_u, bit3 = hrs_d.
- `seg_active_low` in 1: 1 = `seg_in`/`dp_in` inverted on the wire.
- `sel_active_low` in 1: 1 = `sel_in` inverted on the wire.
- `digits_out` out 16: {hrs_d, hrs_u, min_d, min_u}, 4 bits each.
- `dp_out` out 4: point per digit, same bit order as `sel_in`.
- `digit_err` out 4: per digit, last captured glyph was not a legal digit.
- `frame_valid` out 1: one-cycle pulse when `digits_out`/`dp_out`/`digit_err` update.
- `stale` out 1: no scan activity within `TIMEOUT_CYCLES`.

## Operation
- `seg_in`, `dp_in` and `sel_in` pass through a 2-flop synchronizer, then polarity normalization (XOR with the active-low controls; the controls are not synchronized and are assumed static).
- Stability counter: cleared whenever the normalized 12-bit word {sel, dp, seg} differs from the previous cycle; otherwise increments, saturating at `SETTLE_CYCLES`.
- Capture: on the cycle the counter reaches `SETTLE_CYCLES` with sel one-hot, decode the glyph into shadow[digit], store dp and the error flag, and set captured[digit]. Capture happens once per dwell. Non-one-hot sel (including 0) never captures.
- Glyph decode: 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7C→6, 0x07→7, 0x7F→8, 0x67→9. Any other glyph yields nibble 4'hF with the error flag set; 0x00 (blank) is also an error.
- Frame commit: when all four captured bits are set, on the next cycle copy the shadows to the outputs, pulse `frame_valid` and clear captured. A digit recaptured before commit overwrites its shadow.
- Stale: the idle counter clears on every capture and otherwise increments. At `TIMEOUT_CYCLES` it asserts `stale` and clears captured. Outputs hold their last values. `stale` deasserts with the next `frame_valid`.
- Reset values: `digits_out` 0, `dp_out` 0, `digit_err` 0, `frame_valid` 0, `stale` 1. Shadows, captured, counters and synchronizers are all 0.

## Timing
- Input change to first qualifying sample: 2 cycles of synchronizer latency.
- Capture occurs `SETTLE_CYCLES` cycles after the synchronized word last changed. With `SETTLE_CYCLES`=1, capture occurs on the first cycle after a change.
- Fourth capture in cycle N gives `frame_valid` and new outputs in cycle N+1, held until the next commit.
- A capture and a timeout in the same cycle: the capture wins; the idle counter clears and `stale` is unchanged.
- A capture and a commit in the same cycle: the commit uses the previously set captured bits. The new capture sets its bit after the clear.
- Reset asserted mid-frame: everything returns to its reset value immediately, and partial captures are discarded.

## Configuration
- `SEG7_DEC_ALT_GLYPH_EN` defined: additionally accept the alternate glyphs 0x7D→6, 0x6F→9 and 0x27→7 with no error.
- Undefined: only the canonical table applies, and the alternates decode as 4'hF with the error flag set.

## Structure
- Shared package: the ten canonical glyph constants, the alternate glyph constants, and the digit index constants (MIN_U=0 … HRS_D=3) shared with the encoder side.
- One sub-module, `seg7_glyph_decode`: purely combinational, 7-bit glyph in, 4-bit value plus error out. It contains the `SEG7_DEC_ALT_GLYPH_EN` branch.

## Test plan
- Scan digits 1,2,3,4 (min_u=4, min_d=3, hrs_u=2, hrs_d=1) with a 20-cycle dwell each, both polarities 0 → `digits_out`=16'h1234, `frame_valid` one cycle after the hrs_d capture, `digit_err`=0.
- Same scan with `seg_active_low`=1 and `sel_active_low`=1 and all wires inverted → identical outputs.
- Glitch test: a 2-cycle sel pulse 4'b0011, followed by a 3-cycle dwell with `SETTLE_CYCLES`=4 → no capture and no `frame_valid`.
- Glyph 0x7D on min_u → value 4'h6 with `digit_err[0]`=0 when the macro is defined; 4'hF with `digit_err[0]`=1 when undefined.
- Stop scanning with `TIMEOUT_CYCLES`=100 → `stale`=1 at cycle 100 after the last capture with outputs held; a full rescan then clears `stale` together with `frame_valid`.
- Assert `reset` after two captures, release, then scan one full frame → exactly one `frame_valid`, carrying the new values only.
